// File: rtl/calc_pkg.sv
// Shared encodings for the calculator/seven-segment block: operators, FSM states,
// glyph codes and the active-low hex segment table.
package calc_pkg;

   typedef enum logic [1:0] {
      OpDiv = 2'b00,
      OpAdd = 2'b01,
      OpSub = 2'b10,
      OpMul = 2'b11
   } calc_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StExec,
      StDivide,
      StConvert,
      StDone
   } calc_state_e;

   // Glyph codes 0..15 are hex digits; these two extend the code space.
   localparam logic [4:0] GlyphDash  = 5'd16;
   localparam logic [4:0] GlyphBlank = 5'd17;

   localparam logic [6:0] SegDash  = 7'b0111111;
   localparam logic [6:0] SegBlank = 7'b1111111;

   // {g,f,e,d,c,b,a}, active low, index 0 first
   localparam logic [0:15][6:0] HexSeg = {
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Maps a 5-bit glyph code (hex digit, dash or blank) to active-low segments.
module seg7_glyph
   import calc_pkg::*;
(
   input  logic [4:0] glyph,
   output logic [6:0] seg
);

   always_comb begin
      seg = SegBlank;
      if (glyph < 5'd16) begin
         seg = HexSeg[glyph[3:0]];
      end else if (glyph == GlyphDash) begin
         seg = SegDash;
      end
   end

endmodule

// File: rtl/calc_seg_core.sv
// Sequential four-function calculator with double-dabble conversion and a
// multiplexed active-low seven-segment display of operands, sign and result.
module calc_seg_core
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned RES_DIGITS = 3,
   parameter int unsigned SCAN_DIV   = 16,
   localparam int unsigned OPD       = (WIDTH + 3) / 4,
   localparam int unsigned NPOS      = 2 * OPD + 1 + RES_DIGITS,
   localparam int unsigned RW        = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       operator,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [6:0]       wordout,
   output logic [NPOS-1:0]  segout
);

   localparam int unsigned CntW = $clog2(RW);
   localparam int unsigned PosW = $clog2(NPOS);
   localparam int unsigned BcdW = 4 * RES_DIGITS;
   localparam longint unsigned MaxVal  = (64'd1 << WIDTH) - 64'd1;
   localparam longint unsigned MaxProd = MaxVal * MaxVal;

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("calc_seg_core: WIDTH must be within 2..16");
   end
   if (pow10(RES_DIGITS) <= MaxProd) begin : g_bad_digits
      $error("calc_seg_core: RES_DIGITS too small for the largest product");
   end

   calc_state_e       state_q, state_d;
   calc_op_e          op_q, op_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d;
   logic [RW-1:0]     res_q, res_d;
   logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
   logic              neg_q, neg_d, err_q, err_d;
   logic [WIDTH:0]    trial;
   logic [3:0]        dig;

   logic [WIDTH-1:0]  disp_a_q, disp_b_q;
   logic [BcdW-1:0]   disp_bcd_q;
   logic              disp_neg_q, disp_err_q, disp_valid_q;

   logic [SCAN_DIV-1:0] presc_q;
   logic [PosW-1:0]     pos_q;
   logic [4:0]          glyph;
   logic [4*OPD-1:0]    a_pad, b_pad;
   int unsigned         p;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      res_d   = res_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      err_d   = err_q;
      trial   = '0;
      bcd_adj = '0;
      dig     = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = calc_op_e'(operator);
               err_d   = 1'b0;
               state_d = StExec;
            end
         end
         StExec: begin
            cnt_d   = '0;
            rem_d   = '0;
            bcd_d   = '0;
            neg_d   = 1'b0;
            state_d = StConvert;
            unique case (op_q)
               OpAdd: res_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
               OpSub: begin
                  neg_d = (a_q < b_q);
                  res_d = (a_q < b_q) ? {{WIDTH{1'b0}}, b_q - a_q}
                                      : {{WIDTH{1'b0}}, a_q - b_q};
               end
               OpMul: res_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
               OpDiv: begin
                  if (b_q == '0) begin
                     err_d = 1'b1;
                     res_d = '0;
                  end else begin
                     // Dividend shifts out of res_q while quotient bits shift in.
                     res_d   = {{WIDTH{1'b0}}, a_q};
                     state_d = StDivide;
                  end
               end
            endcase
         end
         StDivide: begin
            trial = {rem_q, res_q[WIDTH-1]};
            if (trial >= {1'b0, b_q}) begin
               rem_d = trial[WIDTH-1:0] - b_q;
               res_d = {{WIDTH{1'b0}}, res_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = trial[WIDTH-1:0];
               res_d = {{WIDTH{1'b0}}, res_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CntW'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = StConvert;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StConvert: begin
            for (int i = 0; i < int'(RES_DIGITS); i++) begin
               dig = bcd_q[4*i +: 4];
               bcd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
            end
            bcd_d = BcdW'({bcd_adj, res_q[RW-1]});
            res_d = {res_q[RW-2:0], 1'b0};
            if (cnt_q == CntW'(RW - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= OpDiv;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_a_q     <= '0;
         disp_b_q     <= '0;
         disp_bcd_q   <= '0;
         disp_neg_q   <= 1'b0;
         disp_err_q   <= 1'b0;
         disp_valid_q <= 1'b0;
      end else if (state_q == StDone) begin
         disp_a_q     <= a_q;
         disp_b_q     <= b_q;
         disp_bcd_q   <= bcd_q;
         disp_neg_q   <= neg_q;
         disp_err_q   <= err_q;
         disp_valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         pos_q   <= '0;
      end else begin
         presc_q <= presc_q + SCAN_DIV'(1);
         if (&presc_q) begin
            pos_q <= (pos_q == PosW'(NPOS - 1)) ? '0 : pos_q + PosW'(1);
         end
      end
   end

   assign busy  = (state_q != StIdle);
   assign done  = (state_q == StDone);
   assign err   = err_q;
   assign a_pad = (4 * OPD)'(disp_a_q);
   assign b_pad = (4 * OPD)'(disp_b_q);
   assign p     = int'(pos_q);

   always_comb begin
      glyph = GlyphBlank;
      if (disp_valid_q) begin
         if (p < OPD) begin
            glyph = {1'b0, a_pad[4*(OPD-1-p) +: 4]};
         end else if (p < 2 * OPD) begin
            glyph = {1'b0, b_pad[4*(2*OPD-1-p) +: 4]};
         end else if (p == 2 * OPD) begin
            glyph = (disp_neg_q && !disp_err_q) ? GlyphDash : GlyphBlank;
         end else if (disp_err_q) begin
            glyph = GlyphDash;
         end else begin
            glyph = {1'b0, disp_bcd_q[4*(NPOS-1-p) +: 4]};
         end
      end
   end

   seg7_glyph u_glyph (
      .glyph (glyph),
      .seg   (wordout)
   );

   assign segout = ~(NPOS'(1) << pos_q);

endmodule

// File: tb/tb_calc_seg_core.sv
// Directed bench for calc_seg_core at WIDTH=4, RES_DIGITS=3, SCAN_DIV=2.
module tb_calc_seg_core;

   localparam logic [4:0] BL = 5'd17;
   localparam logic [4:0] DS = 5'd16;

   typedef struct packed {
      logic [3:0]      a;
      logic [3:0]      b;
      logic [1:0]      op;
      logic [4:0]      lat;
      logic            err;
      logic [0:5][4:0] disp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic [1:0] operator = '0;
   logic       start = 1'b0;
   logic       busy, done, err;
   logic [6:0] wordout;
   logic [5:0] segout;

   int n_cmp = 0;
   int n_bad = 0;

   calc_seg_core #(
      .WIDTH      (4),
      .RES_DIGITS (3),
      .SCAN_DIV   (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .operator (operator),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .wordout  (wordout),
      .segout   (segout)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [4:0] code);
      case (code)
         5'd0:  return 7'b1000000;
         5'd1:  return 7'b1111001;
         5'd2:  return 7'b0100100;
         5'd3:  return 7'b0110000;
         5'd4:  return 7'b0011001;
         5'd5:  return 7'b0010010;
         5'd6:  return 7'b0000010;
         5'd7:  return 7'b1111000;
         5'd8:  return 7'b0000000;
         5'd9:  return 7'b0010000;
         5'd10: return 7'b0001000;
         5'd11: return 7'b0000011;
         5'd12: return 7'b1000110;
         5'd13: return 7'b0100001;
         5'd14: return 7'b0000110;
         5'd15: return 7'b0001110;
         5'd16: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Waits for each position in turn and checks its glyph.
   task automatic read_disp(input logic [0:5][4:0] exp, input string tag);
      logic [5:0] want;
      for (int pos = 0; pos < 6; pos++) begin
         want = ~(6'b000001 << pos);
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (segout == want) break;
         end
         check({tag, "_segsel"}, {26'd0, segout}, {26'd0, want});
         check({tag, "_glyph"}, {25'd0, wordout}, {25'd0, seg_of(exp[pos])});
      end
   endtask

   task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] iop,
                         output int lat, output logic err_done);
      @(negedge clk);
      a = ia;
      b = ib;
      operator = iop;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("err_cleared_on_start", {31'd0, err}, 32'd0);
      lat = -1;
      err_done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k + 1;
            err_done = err;
            break;
         end
      end
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   vec_t       vecs[10];
   int         lat;
   int         ndone;
   logic       errd;
   logic [5:0] s, sp;
   int         hold;

   initial begin
      vecs[0] = '{a: 4'd9,  b: 4'd7,  op: 2'b01, lat: 5'd10, err: 1'b0,
                  disp: {5'd9,  5'd7,  BL, 5'd0, 5'd1, 5'd6}};
      vecs[1] = '{a: 4'd3,  b: 4'd12, op: 2'b10, lat: 5'd10, err: 1'b0,
                  disp: {5'd3,  5'd12, DS, 5'd0, 5'd0, 5'd9}};
      vecs[2] = '{a: 4'd15, b: 4'd15, op: 2'b11, lat: 5'd10, err: 1'b0,
                  disp: {5'd15, 5'd15, BL, 5'd2, 5'd2, 5'd5}};
      vecs[3] = '{a: 4'd13, b: 4'd4,  op: 2'b00, lat: 5'd14, err: 1'b0,
                  disp: {5'd13, 5'd4,  BL, 5'd0, 5'd0, 5'd3}};
      vecs[4] = '{a: 4'd5,  b: 4'd0,  op: 2'b00, lat: 5'd10, err: 1'b1,
                  disp: {5'd5,  5'd0,  BL, DS,   DS,   DS}};
      vecs[5] = '{a: 4'd12, b: 4'd3,  op: 2'b10, lat: 5'd10, err: 1'b0,
                  disp: {5'd12, 5'd3,  BL, 5'd0, 5'd0, 5'd9}};
      vecs[6] = '{a: 4'd0,  b: 4'd0,  op: 2'b01, lat: 5'd10, err: 1'b0,
                  disp: {5'd0,  5'd0,  BL, 5'd0, 5'd0, 5'd0}};
      vecs[7] = '{a: 4'd15, b: 4'd1,  op: 2'b00, lat: 5'd14, err: 1'b0,
                  disp: {5'd15, 5'd1,  BL, 5'd0, 5'd1, 5'd5}};
      vecs[8] = '{a: 4'd1,  b: 4'd15, op: 2'b00, lat: 5'd14, err: 1'b0,
                  disp: {5'd1,  5'd15, BL, 5'd0, 5'd0, 5'd0}};
      vecs[9] = '{a: 4'd11, b: 4'd13, op: 2'b11, lat: 5'd10, err: 1'b0,
                  disp: {5'd11, 5'd13, BL, 5'd1, 5'd4, 5'd3}};

      // Reset values
      #2;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_segout", {26'd0, segout}, 32'h3e);
      check("rst_wordout", {25'd0, wordout}, 32'h7f);
      #18 rst_n = 1'b1;
      read_disp({BL, BL, BL, BL, BL, BL}, "blank_after_reset");

      // Scan order and 4-clock hold per position
      s = segout;
      sp = s;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         sp = s;
         s = segout;
         if (s == 6'b111110 && sp == 6'b011111) break;
      end
      check("scan_sync", {26'd0, s}, 32'h3e);
      for (int i = 0; i < 6; i++) begin
         hold = 1;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (segout != s) break;
            hold++;
         end
         check("scan_hold", hold, 32'd4);
         check("scan_next", {26'd0, segout}, {26'd0, ~(6'b000001 << ((i + 1) % 6))});
         s = segout;
      end

      // Table-driven operations; live inputs scrambled before reading the display
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, errd);
         check("latency", lat, {27'd0, vecs[i].lat});
         check("err_at_done", {31'd0, errd}, {31'd0, vecs[i].err});
         a = ~vecs[i].a;
         b = vecs[i].b + 4'd5;
         operator = ~vecs[i].op;
         read_disp(vecs[i].disp, "disp");
         check("err_held", {31'd0, err}, {31'd0, vecs[i].err});
      end

      // Start re-pulsed while busy must be ignored
      @(negedge clk);
      a = 4'd9;
      b = 4'd7;
      operator = 2'b01;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = 4'd1;
      b = 4'd1;
      operator = 2'b11;
      ndone = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = (k == 3 || k == 6);
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      start = 1'b0;
      check("repulse_one_done", ndone, 32'd1);
      check("repulse_idle", {31'd0, busy}, 32'd0);
      read_disp({5'd9, 5'd7, BL, 5'd0, 5'd1, 5'd6}, "repulse_disp");

      // Reset asserted during DIVIDE
      @(negedge clk);
      a = 4'd13;
      b = 4'd4;
      operator = 2'b00;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_segout", {26'd0, segout}, 32'h3e);
      check("midrst_wordout", {25'd0, wordout}, 32'h7f);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("midrst_no_done", ndone, 32'd0);
      read_disp({BL, BL, BL, BL, BL, BL}, "midrst_blank");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
